id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Pipeline register between instruction decode and execute.
- Captures the decoder's control bundle together with operand data, immediate, register indices, funct bits and PC.
- Detects load-use hazards and inserts a one-cycle bubble.
- Honours a flush from branch resolution and a hold from the memory stage.

Parameters:
- XLEN, 32, datapath width of PC, operands and immediate.
- REG_IDX_W, 5, register index width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- id_valid  input  1  ID slot holds a real instruction.
- id_pc  input  XLEN  PC of the ID instruction.
- id_rs1_data, id_rs2_data  input  XLEN each  register-file read data.
- id_imm  input  XLEN  sign-extended immediate.
- id_rs1, id_rs2, id_rd  input  REG_IDX_W each  register indices.
- id_rs2_used  input  1  instruction reads rs2 (R, S, B types).
- id_funct3  input  3  funct3 field.
- id_funct7b5  input  1  instruction bit 30.
- id_branch, id_memRead, id_memToReg, id_memWrite, id_ALUSrc, id_regWrite  input  1 each  decoder control signals.
- id_ALUOp  input  2  decoder ALU operation class.
- flush  input  1  squash the ID instruction (taken branch or jump).
- ex_hold  input  1  downstream stall; freeze the EX register.
- stall  output  1  freeze PC and IF/ID this cycle.
- ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5, ex_branch, ex_memRead, ex_memToReg, ex_memWrite, ex_ALUSrc, ex_regWrite, ex_ALUOp  output  (same widths as inputs)  registered EX copies.

Behaviour:
- Reset: every ex_* output is 0, including ex_valid and all control bits.
- hazard (combinational) = ex_valid & ex_memRead & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (id_rs2_used & ex_rd == id_rs2)).
- stall = ~flush & (hazard | ex_hold). Purely combinational; it must be valid in the same cycle.
- Update priority per edge:
  1. rst: clear everything.
  2. flush: load a bubble (ex_valid=0, all control bits 0, data fields 0). flush overrides both hold and hazard.
  3. ex_hold: all ex_* keep their values.
  4. hazard: load a bubble.
  5. Otherwise load every id_* into ex_*. ex_valid = id_valid. If id_valid=0, control bits load as 0.
- Latency: 1 cycle from ID to EX.
- A load-use stall lasts exactly 1 cycle. The bubble clears ex_memRead, so hazard drops on the next cycle with no extra state.
- rd = x0 never triggers a hazard.
- Back-to-back loads with a dependency stall once per dependent consumer.
- ex_hold asserted during a hazard: the EX register is held, stall stays high, and the bubble is inserted after the hold releases if the hazard still exists.
- Reset mid-stall: all state clears, so stall deasserts on the following cycle.
- Invariant: control bits are never non-zero while ex_valid=0.

Optional Feature:
- Macro: IDEX_PERF_CNT_EN.
- Defined:
  - Adds output bubble_count[31:0], which increments on every edge that inserts a hazard bubble (cases 2 and 3 of the priority do not count).
  - Adds output flush_count[31:0], which increments on every flush edge.
  - Both counters reset to 0 and wrap modulo 2^32.
- Undefined: neither port nor counter exists. Behaviour is otherwise identical.

Decomposition:
- parameters.vh carries:
  - opcode constants;
  - ALUOp encodings;
  - a new CTRL_W constant (8), the width of the packed control bundle;
  - bit-position constants for that bundle.
- Sub-module load_use_detect (combinational):
  - inputs: ex_valid, ex_memRead, ex_rd, id_valid, id_rs1, id_rs2, id_rs2_used;
  - output: hazard.
- The top level holds the register and the priority logic.

Test Plan:
- Reset: hold rst=1 for 2 cycles with random id_* inputs -> all ex_* = 0 and stall = 0.
- Pass-through: addi x5,x1,3 (id_rd=5, id_imm=3, regWrite=1, ALUSrc=1, ALUOp=arithmetic) -> the next cycle shows ex_rd=5, ex_imm=3, ex_regWrite=1, ex_valid=1, stall=0.
- Load-use: lw x6 followed by add x7,x6,x2 -> while the add is in ID, stall=1 for exactly 1 cycle. EX then shows a bubble (ex_valid=0, all control 0), and the add reaches EX on the following cycle. Repeat with add x7,x2,x6 and id_rs2_used=1 for the same result; with id_rs2_used=0 there is no stall.
- x0 case: lw x0 followed by add x7,x0,x0 -> stall stays 0.
- Flush priority: set flush=1 during a load-use hazard with ex_hold=1 -> stall=0 and EX becomes a bubble on the next edge.
- Hold: ex_hold=1 for 3 cycles with changing id_* -> ex_* is unchanged and stall=1 throughout. Under IDEX_PERF_CNT_EN, run 2 load-use stalls and 1 flush -> bubble_count=2 and flush_count=1.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared constants for the ID/EX pipeline register:
//   - RV32I major opcode constants
//   - ALUOp class encodings produced by the decoder
//   - CTRL_W: width of the packed decoder control bundle
//   - bit positions of each control signal inside that bundle
//   - pack_ctrl(): assembles the bundle from individual control bits
// -----------------------------------------------------------------------------
package id_ex_stage_pkg;

    // Major opcodes
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALUOp classes
    localparam logic [1:0] ALUOP_ADD    = 2'b00;  // address calculation
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;  // compare for branch
    localparam logic [1:0] ALUOP_ARITH  = 2'b10;  // decode funct3/funct7
    localparam logic [1:0] ALUOP_RSVD   = 2'b11;

    // Packed control bundle layout
    localparam int CTRL_W       = 8;
    localparam int CTRL_BRANCH   = 7;
    localparam int CTRL_MEMREAD  = 6;
    localparam int CTRL_MEMTOREG = 5;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_REGWRITE = 2;
    localparam int CTRL_ALUOP_HI = 1;
    localparam int CTRL_ALUOP_LO = 0;

    function automatic logic [CTRL_W-1:0] pack_ctrl(
        input logic       branch,
        input logic       mem_read,
        input logic       mem_to_reg,
        input logic       mem_write,
        input logic       alu_src,
        input logic       reg_write,
        input logic [1:0] alu_op
    );
        logic [CTRL_W-1:0] c;
        c                              = '0;
        c[CTRL_BRANCH]                 = branch;
        c[CTRL_MEMREAD]                = mem_read;
        c[CTRL_MEMTOREG]               = mem_to_reg;
        c[CTRL_MEMWRITE]               = mem_write;
        c[CTRL_ALUSRC]                 = alu_src;
        c[CTRL_REGWRITE]               = reg_write;
        c[CTRL_ALUOP_HI:CTRL_ALUOP_LO] = alu_op;
        return c;
    endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard detector. Flags the case where the
// instruction now in EX is a load whose destination is read by the
// instruction now in ID. A load to x0 never produces a hazard.
// Ports:
//   ex_valid, ex_memRead, ex_rd          : EX-stage instruction
//   id_valid, id_rs1, id_rs2, id_rs2_used: ID-stage instruction
//   hazard                               : one-cycle bubble required
// -----------------------------------------------------------------------------
module load_use_detect #(
    parameter int REG_IDX_W = 5
) (
    input  logic                 ex_valid,
    input  logic                 ex_memRead,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_rs2_used,
    output logic                 hazard
);

    logic rd_nonzero;
    logic src_match;

    assign rd_nonzero = (ex_rd != '0);
    // rs2 only matters for formats that actually read it (R, S, B)
    assign src_match  = (ex_rd == id_rs1) | (id_rs2_used & (ex_rd == id_rs2));
    assign hazard     = ex_valid & ex_memRead & rd_nonzero & id_valid & src_match;

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// Pipeline register between instruction decode and execute. Captures the
// decoder control bundle, operands, immediate, register indices, funct bits
// and PC. Inserts a one-cycle bubble on a load-use hazard, squashes the ID
// instruction on flush and freezes on a downstream hold.
// Update priority on each rising edge: rst > flush > ex_hold > hazard > load.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   id_*                : decoded instruction from ID
//   flush               : squash ID instruction (taken branch / jump)
//   ex_hold             : freeze the EX register
//   stall               : combinational, freeze PC and IF/ID this cycle
//   ex_*                : registered EX copies of the id_* inputs
// Optional feature (macro IDEX_PERF_CNT_EN):
//   bubble_count[31:0]  : hazard bubbles inserted (wraps)
//   flush_count[31:0]   : flush edges seen (wraps)
// -----------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [XLEN-1:0]      id_pc,
    input  logic [XLEN-1:0]      id_rs1_data,
    input  logic [XLEN-1:0]      id_rs2_data,
    input  logic [XLEN-1:0]      id_imm,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_rs2_used,
    input  logic [2:0]           id_funct3,
    input  logic                 id_funct7b5,
    input  logic                 id_branch,
    input  logic                 id_memRead,
    input  logic                 id_memToReg,
    input  logic                 id_memWrite,
    input  logic                 id_ALUSrc,
    input  logic                 id_regWrite,
    input  logic [1:0]           id_ALUOp,
    input  logic                 flush,
    input  logic                 ex_hold,
    output logic                 stall,
    output logic                 ex_valid,
    output logic [XLEN-1:0]      ex_pc,
    output logic [XLEN-1:0]      ex_rs1_data,
    output logic [XLEN-1:0]      ex_rs2_data,
    output logic [XLEN-1:0]      ex_imm,
    output logic [REG_IDX_W-1:0] ex_rs1,
    output logic [REG_IDX_W-1:0] ex_rs2,
    output logic [REG_IDX_W-1:0] ex_rd,
    output logic [2:0]           ex_funct3,
    output logic                 ex_funct7b5,
    output logic                 ex_branch,
    output logic                 ex_memRead,
    output logic                 ex_memToReg,
    output logic                 ex_memWrite,
    output logic                 ex_ALUSrc,
    output logic                 ex_regWrite,
`ifdef IDEX_PERF_CNT_EN
    output logic [1:0]           ex_ALUOp,
    output logic [31:0]          bubble_count,
    output logic [31:0]          flush_count
`else
    output logic [1:0]           ex_ALUOp
`endif
);

    logic                 hazard;
    logic                 bubble;
    logic [CTRL_W-1:0]    id_ctrl;

    logic                 valid_q,   valid_d;
    logic [XLEN-1:0]      pc_q,      pc_d;
    logic [XLEN-1:0]      rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]      rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]      imm_q,     imm_d;
    logic [REG_IDX_W-1:0] rs1_q,     rs1_d;
    logic [REG_IDX_W-1:0] rs2_q,     rs2_d;
    logic [REG_IDX_W-1:0] rd_q,      rd_d;
    logic [2:0]           funct3_q,  funct3_d;
    logic                 funct7b5_q, funct7b5_d;
    logic [CTRL_W-1:0]    ctrl_q,    ctrl_d;

    load_use_detect #(
        .REG_IDX_W (REG_IDX_W)
    ) u_load_use_detect (
        .ex_valid    (valid_q),
        .ex_memRead  (ctrl_q[CTRL_MEMREAD]),
        .ex_rd       (rd_q),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs2_used (id_rs2_used),
        .hazard      (hazard)
    );

    // A flush squashes the ID instruction anyway, so there is nothing to
    // wait for: stall is suppressed even while hold or hazard is active.
    assign stall = ~flush & (hazard | ex_hold);

    // Bubble on flush (overrides hold) or on a hazard that is not held.
    assign bubble = flush | (~ex_hold & hazard);

    assign id_ctrl = pack_ctrl(id_branch, id_memRead, id_memToReg, id_memWrite,
                               id_ALUSrc, id_regWrite, id_ALUOp);

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        funct3_d   = funct3_q;
        funct7b5_d = funct7b5_q;
        ctrl_d     = ctrl_q;
        if (bubble) begin
            valid_d    = 1'b0;
            pc_d       = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            imm_d      = '0;
            rs1_d      = '0;
            rs2_d      = '0;
            rd_d       = '0;
            funct3_d   = '0;
            funct7b5_d = 1'b0;
            ctrl_d     = '0;
        end else if (!ex_hold) begin
            valid_d    = id_valid;
            pc_d       = id_pc;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rd_d       = id_rd;
            funct3_d   = id_funct3;
            funct7b5_d = id_funct7b5;
            // Control never rides along with an invalid slot
            ctrl_d     = id_valid ? id_ctrl : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            funct3_q   <= '0;
            funct7b5_q <= 1'b0;
            ctrl_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            funct3_q   <= funct3_d;
            funct7b5_q <= funct7b5_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_pc       = pc_q;
    assign ex_rs1_data = rs1_data_q;
    assign ex_rs2_data = rs2_data_q;
    assign ex_imm      = imm_q;
    assign ex_rs1      = rs1_q;
    assign ex_rs2      = rs2_q;
    assign ex_rd       = rd_q;
    assign ex_funct3   = funct3_q;
    assign ex_funct7b5 = funct7b5_q;
    assign ex_branch   = ctrl_q[CTRL_BRANCH];
    assign ex_memRead  = ctrl_q[CTRL_MEMREAD];
    assign ex_memToReg = ctrl_q[CTRL_MEMTOREG];
    assign ex_memWrite = ctrl_q[CTRL_MEMWRITE];
    assign ex_ALUSrc   = ctrl_q[CTRL_ALUSRC];
    assign ex_regWrite = ctrl_q[CTRL_REGWRITE];
    assign ex_ALUOp    = ctrl_q[CTRL_ALUOP_HI:CTRL_ALUOP_LO];

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] flush_cnt_q,  flush_cnt_d;

    // Only hazard bubbles count here; flush-induced bubbles go to flush_count.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (flush) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end else if (!ex_hold && hazard) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bubble_count = bubble_cnt_q;
    assign flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Self-checking bench for id_ex_stage: directed scenarios (reset, pass-through,
// load-use on rs1/rs2, x0, flush priority, hold) followed by randomized
// traffic compared against a behavioural model of the EX register.
// Optional counters checked when IDEX_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        f7;
        logic        br;
        logic        mr;
        logic        m2r;
        logic        mw;
        logic        as;
        logic        rw;
        logic [1:0]  op;
    } slot_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  flush;
    logic  hold;
    logic  rs2_used;
    slot_t id;
    slot_t act;
    slot_t m;      // model of the EX register
    slot_t snap;

    logic        stall;
    logic        ex_valid, ex_f7, ex_br, ex_mr, ex_m2r, ex_mw, ex_as, ex_rw;
    logic [31:0] ex_pc, ex_rs1d, ex_rs2d, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_f3;
    logic [1:0]  ex_op;
    logic        last_stall;
    logic [31:0] exp_bub, exp_fl;
`ifdef IDEX_PERF_CNT_EN
    logic [31:0] bubble_count, flush_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id.valid),
        .id_pc       (id.pc),
        .id_rs1_data (id.rs1d),
        .id_rs2_data (id.rs2d),
        .id_imm      (id.imm),
        .id_rs1      (id.rs1),
        .id_rs2      (id.rs2),
        .id_rd       (id.rd),
        .id_rs2_used (rs2_used),
        .id_funct3   (id.f3),
        .id_funct7b5 (id.f7),
        .id_branch   (id.br),
        .id_memRead  (id.mr),
        .id_memToReg (id.m2r),
        .id_memWrite (id.mw),
        .id_ALUSrc   (id.as),
        .id_regWrite (id.rw),
        .id_ALUOp    (id.op),
        .flush       (flush),
        .ex_hold     (hold),
        .stall       (stall),
        .ex_valid    (ex_valid),
        .ex_pc       (ex_pc),
        .ex_rs1_data (ex_rs1d),
        .ex_rs2_data (ex_rs2d),
        .ex_imm      (ex_imm),
        .ex_rs1      (ex_rs1),
        .ex_rs2      (ex_rs2),
        .ex_rd       (ex_rd),
        .ex_funct3   (ex_f3),
        .ex_funct7b5 (ex_f7),
        .ex_branch   (ex_br),
        .ex_memRead  (ex_mr),
        .ex_memToReg (ex_m2r),
        .ex_memWrite (ex_mw),
        .ex_ALUSrc   (ex_as),
        .ex_regWrite (ex_rw),
`ifdef IDEX_PERF_CNT_EN
        .ex_ALUOp    (ex_op),
        .bubble_count(bubble_count),
        .flush_count (flush_count)
`else
        .ex_ALUOp    (ex_op)
`endif
    );

    always_comb begin
        act = '{valid: ex_valid, pc: ex_pc, rs1d: ex_rs1d, rs2d: ex_rs2d,
                imm: ex_imm, rs1: ex_rs1, rs2: ex_rs2, rd: ex_rd, f3: ex_f3,
                f7: ex_f7, br: ex_br, mr: ex_mr, m2r: ex_m2r, mw: ex_mw,
                as: ex_as, rw: ex_rw, op: ex_op};
    end

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: check stall mid-cycle, advance the model, check EX after edge.
    task automatic step(input bit chk_stall);
        logic hz;
        logic exp_stall;
        @(negedge clk);
        hz = m.valid && m.mr && (m.rd != 5'd0) && id.valid &&
             ((m.rd == id.rs1) || (rs2_used && (m.rd == id.rs2)));
        exp_stall = !flush && (hz || hold);
        last_stall = stall;
        if (chk_stall) check("stall", stall, exp_stall);
        @(posedge clk);
        if (rst) begin
            m = '0; exp_bub = 0; exp_fl = 0;
        end else if (flush) begin
            m = '0; exp_fl = exp_fl + 1;
        end else if (hold) begin
            m = m;
        end else if (hz) begin
            m = '0; exp_bub = exp_bub + 1;
        end else begin
            m = id;
            if (!id.valid) begin
                m.br = 0; m.mr = 0; m.m2r = 0; m.mw = 0; m.as = 0; m.rw = 0; m.op = 0;
            end
        end
        #1;
        check("ex_bundle", act, m);
`ifdef IDEX_PERF_CNT_EN
        check("bubble_count", bubble_count, exp_bub);
        check("flush_count", flush_count, exp_fl);
`endif
    endtask

    task automatic rand_id();
        id.valid = ($urandom_range(0, 3) != 0);
        id.pc    = $urandom; id.rs1d = $urandom; id.rs2d = $urandom; id.imm = $urandom;
        id.rs1   = 5'($urandom_range(0, 3));
        id.rs2   = 5'($urandom_range(0, 3));
        id.rd    = 5'($urandom_range(0, 3));
        id.f3    = 3'($urandom); id.f7 = 1'($urandom);
        id.br    = 1'($urandom); id.mr = 1'($urandom); id.m2r = 1'($urandom);
        id.mw    = 1'($urandom); id.as = 1'($urandom); id.rw = 1'($urandom);
        id.op    = 2'($urandom);
        rs2_used = 1'($urandom);
    endtask

    // ALU/load instruction in ID
    task automatic instr(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                         input logic use2, input logic ld, input logic [31:0] imm);
        id = '0;
        id.valid = 1; id.pc = 32'h100 + {27'd0, rd}; id.rd = rd; id.rs1 = r1; id.rs2 = r2;
        id.imm = imm; id.rw = 1; id.rs1d = 32'h11; id.rs2d = 32'h22;
        id.mr = ld; id.m2r = ld; id.as = ld | ~use2;
        id.op = ld ? 2'b00 : 2'b10;
        rs2_used = use2;
    endtask

    initial begin
        m = '0; exp_bub = 0; exp_fl = 0; last_stall = 0;
        rst = 1; flush = 0; hold = 0; rs2_used = 0;
        rand_id();
        #1;
        // Reset: two cycles with random ID inputs
        step(0);
        rand_id();
        step(1);
        check("reset_ex", act, 160'd0);
        rst = 0;

        // Pass-through: addi x5,x1,3
        instr(5, 1, 0, 0, 0, 32'd3);
        step(1);
        check("pt_stall", last_stall, 0);
        check("pt_rd", act.rd, 5);
        check("pt_imm", act.imm, 3);
        check("pt_regwrite", act.rw, 1);
        check("pt_valid", act.valid, 1);
        check("pt_aluop", act.op, 2'b10);

        // Load-use through rs1, then through rs2
        for (int k = 0; k < 2; k++) begin
            instr(6, 1, 0, 0, 1, 32'd0);
            step(1);
            if (k == 0) instr(7, 6, 2, 1, 0, 32'd0);
            else        instr(7, 2, 6, 1, 0, 32'd0);
            step(1);
            check("lu_stall", last_stall, 1);
            check("lu_bubble", act, 160'd0);
            step(1);
            check("lu_stall_gone", last_stall, 0);
            check("lu_add_rd", act.rd, 7);
            check("lu_add_valid", act.valid, 1);
        end

        // rs2 match but rs2 not read: no stall
        instr(6, 1, 0, 0, 1, 32'd0);
        step(1);
        instr(7, 2, 6, 0, 0, 32'd0);
        step(1);
        check("nors2_stall", last_stall, 0);
        check("nors2_rd", act.rd, 7);

        // Load to x0 never stalls
        instr(0, 1, 0, 0, 1, 32'd0);
        step(1);
        instr(7, 0, 0, 1, 0, 32'd0);
        step(1);
        check("x0_stall", last_stall, 0);
        check("x0_rd", act.rd, 7);

        // Flush beats hold and hazard
        instr(6, 1, 0, 0, 1, 32'd0);
        step(1);
        instr(7, 6, 2, 1, 0, 32'd0);
        flush = 1; hold = 1;
        step(1);
        check("fl_stall", last_stall, 0);
        check("fl_bubble", act, 160'd0);
        flush = 0; hold = 0;

        // Hold for three cycles with changing ID
        instr(5, 1, 0, 0, 0, 32'd3);
        step(1);
        snap = act;
        hold = 1;
        for (int k = 0; k < 3; k++) begin
            rand_id();
            step(1);
            check("hold_stall", last_stall, 1);
            check("hold_ex", act, snap);
        end
        hold = 0;

`ifdef IDEX_PERF_CNT_EN
        check("perf_bubbles", bubble_count, 32'd2);
        check("perf_flushes", flush_count, 32'd1);
`endif

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            rst   = ($urandom_range(0, 59) == 0);
            flush = ($urandom_range(0, 9) == 0);
            hold  = ($urandom_range(0, 6) == 0);
            rand_id();
            step(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
